dmem_lsu: RTL and testbench

- Parametrised data memory with load/store unit front-end for the single-cycle/multicycle RISC-V core; successor to the fixed 16-word data RAM.
- Supports RV32I sub-word accesses (LB/LH/LW/LBU/LHU, SB/SH/SW) with byte-lane writes and sign/zero extension.
- Adds a req/rsp handshake, alignment and range checking, and a post-reset clearing sweep, so no large async-reset array is needed.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/dmem_bank.sv | 37 +++
 rtl/dmem_lsu.sv | 156 +++++++++++++++
 tb/tb_dmem_lsu.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: RV32I funct3 size codes,
// the controller state encoding and the load-data extension mux.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Shift the addressed byte/half down to bit 0, then sign- or zero-extend.
    function automatic logic [31:0] load_extend(input logic [2:0]  funct3,
                                                input logic [1:0]  lane,
                                                input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (funct3)
            F3_B:    load_extend = {{24{sh[7]}}, sh[7:0]};
            F3_H:    load_extend = {{16{sh[15]}}, sh[15:0]};
            F3_BU:   load_extend = {24'h0, sh[7:0]};
            F3_HU:   load_extend = {16'h0, sh[15:0]};
            default: load_extend = sh;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-addressed data RAM built from four byte-wide arrays.
// Ports: clk; en/we select a write (we=1) or a registered read (we=0) of word idx;
// be enables individual byte lanes on writes; rdata holds the last word read.
// The arrays carry no reset so the bank can map onto block RAM.
module dmem_bank #(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           en,
    input  logic                           we,
    input  logic [3:0]                     be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [7:0] mem [DEPTH_WORDS];
        logic [7:0] rd;

        // One byte lane: masked write or registered read, never both in a cycle.
        always_ff @(posedge clk) begin
            if (en) begin
                if (we) begin
                    if (be[i]) begin
                        mem[idx] <= wdata[8*i +: 8];
                    end
                end else begin
                    rd <= mem[idx];
                end
            end
        end

        assign rdata[8*i +: 8] = rd;
    end

endmodule

// File: rtl/dmem_lsu.sv
// Data memory with RV32I load/store front-end.
// Ports: clk, reset (async, active-high); req_valid/req_ready handshake with
// req_we, req_funct3, req_addr, req_wdata; rsp_valid pulses one cycle after each
// accepted request with rsp_rdata (extended load data) and rsp_err; busy is high
// while the post-reset clearing sweep runs.
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS    = 256,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);
    localparam logic [AW-1:0] LAST = AW'(DEPTH_WORDS - 1);

    state_t        state, state_nxt;
    logic [AW-1:0] clr_cnt, clr_cnt_nxt;

    logic [31:0]   offset;
    logic [1:0]    lane;
    logic          accept, misaligned, out_of_range, illegal, err;
    logic [3:0]    store_be;
    logic [31:0]   store_data;

    logic          bank_en, bank_we;
    logic [3:0]    bank_be;
    logic [AW-1:0] bank_idx;
    logic [31:0]   bank_wdata, bank_rdata;

    logic          ld_q;
    logic [2:0]    f3_q;
    logic [1:0]    lane_q;

    // Request decode. Because BASE_ADDR is span-aligned, an address below the base
    // wraps to an offset >= SPAN, so one unsigned compare covers both range limits.
    always_comb begin
        offset       = req_addr - BASE_ADDR;
        lane         = req_addr[1:0];
        accept       = req_valid && req_ready;
        out_of_range = (offset >= SPAN);
        misaligned   = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && lane[0])
                     || ((req_funct3 == F3_W) && (lane != 2'd0));
        case (req_funct3)
            F3_B, F3_H, F3_W: illegal = 1'b0;
            F3_BU, F3_HU:     illegal = req_we;
            default:          illegal = 1'b1;
        endcase
        err = misaligned || out_of_range || illegal;

        // Replicate store data across lanes; the byte enable picks the target lanes.
        case (req_funct3)
            F3_B: begin
                store_be   = 4'b0001 << lane;
                store_data = {4{req_wdata[7:0]}};
            end
            F3_H: begin
                store_be   = 4'b0011 << lane;
                store_data = {2{req_wdata[15:0]}};
            end
            default: begin
                store_be   = 4'b1111;
                store_data = req_wdata;
            end
        endcase
    end

    // Next state and bank port control: clearing sweep in INIT, requests in RUN.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        bank_en     = 1'b0;
        bank_we     = 1'b0;
        bank_be     = 4'b0000;
        bank_idx    = offset[AW+1:2];
        bank_wdata  = 32'h0;
        case (state)
            INIT: begin
                if (CLEAR_ON_RESET) begin
                    bank_en     = 1'b1;
                    bank_we     = 1'b1;
                    bank_be     = 4'b1111;
                    bank_idx    = clr_cnt;
                    clr_cnt_nxt = clr_cnt + AW'(1);
                    if (clr_cnt == LAST) begin
                        state_nxt = RUN;
                    end
                end else begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                bank_en    = accept && !err;
                bank_we    = req_we;
                bank_be    = store_be;
                bank_wdata = store_data;
            end
            default: state_nxt = INIT;
        endcase
    end

    // State, handshake and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= INIT;
            clr_cnt   <= '0;
            req_ready <= 1'b0;
            busy      <= CLEAR_ON_RESET;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            ld_q      <= 1'b0;
            f3_q      <= F3_W;
            lane_q    <= 2'd0;
        end else begin
            state     <= state_nxt;
            clr_cnt   <= clr_cnt_nxt;
            req_ready <= (state_nxt == RUN);
            busy      <= (state_nxt == INIT);
            rsp_valid <= accept;
            rsp_err   <= accept && err;
            ld_q      <= accept && !req_we && !err;
            f3_q      <= req_funct3;
            lane_q    <= lane;
        end
    end

    // The bank output is already a register; only the lane/extend mux sits after it.
    assign rsp_rdata = ld_q ? load_extend(f3_q, lane_q, bank_rdata) : 32'h0;

    dmem_bank #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_bank (
        .clk   (clk),
        .en    (bank_en),
        .we    (bank_we),
        .be    (bank_be),
        .idx   (bank_idx),
        .wdata (bank_wdata),
        .rdata (bank_rdata)
    );

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed testbench for dmem_lsu with a 16-word memory at address 0.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] exp;
    } vec_t;

    always #5 clk = ~clk;

    dmem_lsu #(
        .DEPTH_WORDS   (16),
        .BASE_ADDR     (32'h0000_0000),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    task automatic drive(input vec_t v);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
    endtask

    task automatic idle();
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
    endtask

    task automatic test_reset();
        int  n;
        logic ready_seen;
        reset = 1'b1;
        idle();
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata, busy} !== {1'b0, 1'b0, 1'b0, 32'h0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_values: ready=%b v=%b e=%b d=%h busy=%b, want 0 0 0 00000000 1",
                     req_ready, rsp_valid, rsp_err, rsp_rdata, busy);
        end
        reset = 1'b0;
        n = 0;
        ready_seen = 1'b0;
        while (busy && n < 100) begin
            if (req_ready) ready_seen = 1'b1;
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n != 16 || ready_seen !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL sweep_length: busy cycles=%0d ready_during_busy=%b ready_after=%b, want 16 0 1",
                     n, ready_seen, req_ready);
        end
        drive('{we:1'b0, f3:3'b010, addr:32'h3C, wdata:32'h0, err:1'b0, exp:32'h0});
        @(negedge clk);
        idle();
        vectors++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL lw_cleared_0x3c: got v=%b e=%b d=%h, want v=1 e=0 d=00000000",
                     rsp_valid, rsp_err, rsp_rdata);
        end
    endtask

    task automatic test_subword();
        vec_t v [8];
        v = '{
            '{we:1'b1, f3:3'b010, addr:32'h08, wdata:32'hDEADBEEF, err:1'b0, exp:32'h00000000},
            '{we:1'b0, f3:3'b000, addr:32'h08, wdata:32'h0, err:1'b0, exp:32'hFFFFFFEF},
            '{we:1'b0, f3:3'b100, addr:32'h0B, wdata:32'h0, err:1'b0, exp:32'h000000DE},
            '{we:1'b0, f3:3'b001, addr:32'h08, wdata:32'h0, err:1'b0, exp:32'hFFFFBEEF},
            '{we:1'b0, f3:3'b101, addr:32'h0A, wdata:32'h0, err:1'b0, exp:32'h0000DEAD},
            '{we:1'b0, f3:3'b010, addr:32'h08, wdata:32'h0, err:1'b0, exp:32'hDEADBEEF},
            '{we:1'b0, f3:3'b000, addr:32'h0B, wdata:32'h0, err:1'b0, exp:32'hFFFFFFDE},
            '{we:1'b0, f3:3'b001, addr:32'h0A, wdata:32'h0, err:1'b0, exp:32'hFFFFDEAD}
        };
        for (int i = 0; i < 8; i++) begin
            drive(v[i]);
            @(negedge clk);
            vectors++;
            if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, v[i].err, v[i].exp}) begin
                miscompares++;
                $display("FAIL subword[%0d]: got v=%b e=%b d=%h, want v=1 e=%b d=%h",
                         i, rsp_valid, rsp_err, rsp_rdata, v[i].err, v[i].exp);
            end
        end
        idle();
    endtask

    task automatic test_lane_merge();
        vec_t v [4];
        v = '{
            '{we:1'b1, f3:3'b000, addr:32'h09, wdata:32'h00000055, err:1'b0, exp:32'h00000000},
            '{we:1'b0, f3:3'b010, addr:32'h08, wdata:32'h0, err:1'b0, exp:32'hDEAD55EF},
            '{we:1'b1, f3:3'b001, addr:32'h0A, wdata:32'h00001234, err:1'b0, exp:32'h00000000},
            '{we:1'b0, f3:3'b010, addr:32'h08, wdata:32'h0, err:1'b0, exp:32'h123455EF}
        };
        for (int i = 0; i < 4; i++) begin
            drive(v[i]);
            @(negedge clk);
            vectors++;
            if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, v[i].err, v[i].exp}) begin
                miscompares++;
                $display("FAIL lane_merge[%0d]: got v=%b e=%b d=%h, want v=1 e=%b d=%h",
                         i, rsp_valid, rsp_err, rsp_rdata, v[i].err, v[i].exp);
            end
        end
        idle();
    endtask

    task automatic test_errors();
        vec_t v [7];
        v = '{
            '{we:1'b0, f3:3'b001, addr:32'h01, wdata:32'h0, err:1'b1, exp:32'h0},
            '{we:1'b1, f3:3'b010, addr:32'h06, wdata:32'hFFFFFFFF, err:1'b1, exp:32'h0},
            '{we:1'b0, f3:3'b010, addr:32'h40, wdata:32'h0, err:1'b1, exp:32'h0},
            '{we:1'b0, f3:3'b011, addr:32'h04, wdata:32'h0, err:1'b1, exp:32'h0},
            '{we:1'b1, f3:3'b100, addr:32'h04, wdata:32'hFFFFFFFF, err:1'b1, exp:32'h0},
            '{we:1'b0, f3:3'b010, addr:32'h04, wdata:32'h0, err:1'b0, exp:32'h0},
            '{we:1'b0, f3:3'b000, addr:32'h3F, wdata:32'h0, err:1'b0, exp:32'h0}
        };
        for (int i = 0; i < 7; i++) begin
            drive(v[i]);
            @(negedge clk);
            vectors++;
            if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, v[i].err, v[i].exp}) begin
                miscompares++;
                $display("FAIL errors[%0d]: got v=%b e=%b d=%h, want v=1 e=%b d=%h",
                         i, rsp_valid, rsp_err, rsp_rdata, v[i].err, v[i].exp);
            end
        end
        idle();
    endtask

    task automatic test_back_to_back();
        vec_t v [8];
        v = '{
            '{we:1'b1, f3:3'b010, addr:32'h10, wdata:32'h11223344, err:1'b0, exp:32'h00000000},
            '{we:1'b0, f3:3'b010, addr:32'h10, wdata:32'h0, err:1'b0, exp:32'h11223344},
            '{we:1'b1, f3:3'b000, addr:32'h13, wdata:32'h000000AA, err:1'b0, exp:32'h00000000},
            '{we:1'b0, f3:3'b010, addr:32'h10, wdata:32'h0, err:1'b0, exp:32'hAA223344},
            '{we:1'b1, f3:3'b001, addr:32'h14, wdata:32'h0000BBCC, err:1'b0, exp:32'h00000000},
            '{we:1'b0, f3:3'b101, addr:32'h14, wdata:32'h0, err:1'b0, exp:32'h0000BBCC},
            '{we:1'b0, f3:3'b000, addr:32'h13, wdata:32'h0, err:1'b0, exp:32'hFFFFFFAA},
            '{we:1'b0, f3:3'b001, addr:32'h12, wdata:32'h0, err:1'b0, exp:32'hFFFFAA22}
        };
        for (int i = 0; i < 8; i++) begin
            drive(v[i]);
            @(negedge clk);
            vectors++;
            if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, v[i].err, v[i].exp}) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: got rdy=%b v=%b e=%b d=%h, want rdy=1 v=1 e=%b d=%h",
                         i, req_ready, rsp_valid, rsp_err, rsp_rdata, v[i].err, v[i].exp);
            end
        end
        idle();
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL back_to_back_tail: got rsp_valid=%b after idle, want 0", rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        drive('{we:1'b0, f3:3'b010, addr:32'h08, wdata:32'h0, err:1'b0, exp:32'h0});
        @(negedge clk);
        vectors++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h123455EF}) begin
            miscompares++;
            $display("FAIL burst_before_reset: got v=%b e=%b d=%h, want v=1 e=0 d=123455ef",
                     rsp_valid, rsp_err, rsp_rdata);
        end
        drive('{we:1'b0, f3:3'b010, addr:32'h10, wdata:32'h0, err:1'b0, exp:32'h0});
        @(posedge clk);
        #1;
        vectors++;
        if (rsp_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL inflight_pulse: got rsp_valid=%b, want 1", rsp_valid);
        end
        reset = 1'b1;
        idle();
        #1;
        vectors++;
        if ({rsp_valid, rsp_rdata, req_ready, busy} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_drops_rsp: got v=%b d=%h rdy=%b busy=%b, want 0 00000000 0 1",
                     rsp_valid, rsp_rdata, req_ready, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++;
        if ({busy, req_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_in_sweep: got busy=%b rdy=%b, want busy=1 rdy=0", busy, req_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n != 16 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL sweep_restart: busy cycles=%0d rdy=%b, want 16 1", n, req_ready);
        end
        drive('{we:1'b0, f3:3'b010, addr:32'h08, wdata:32'h0, err:1'b0, exp:32'h0});
        @(negedge clk);
        vectors++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL cleared_0x08: got v=%b e=%b d=%h, want v=1 e=0 d=00000000",
                     rsp_valid, rsp_err, rsp_rdata);
        end
        drive('{we:1'b0, f3:3'b010, addr:32'h10, wdata:32'h0, err:1'b0, exp:32'h0});
        @(negedge clk);
        vectors++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL cleared_0x10: got v=%b e=%b d=%h, want v=1 e=0 d=00000000",
                     rsp_valid, rsp_err, rsp_rdata);
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_subword();
        test_lane_merge();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
